sd_slv_dtx: RTL
===============

// Module: sd_slv_dtx
// PURPOSE
//  SD slave single-line (DAT0) read-data block transmitter. Takes bytes over a valid/ready stream,
//  frames them as start bit, data MSB-first, CRC16, end bit. Sequences the CRC16 generator
//  (clr/cen/sft/din, serial q). Sits between the card data buffer and the DAT pad driver,
//  advancing one bit per sd_ce strobe of the host-driven bus clock.
// PARAMETERS
//  BLKW      12   width of blk_len; max block = 2**BLKW-1 bytes
// PORTS
//  clk       in   1     system clock
//  rst       in   1     asynchronous, active-high reset
//  sd_ce     in   1     bit strobe; all bus outputs/state advance only on clk with sd_ce=1
//  start     in   1     pulse: begin a block (sampled in IDLE only)
//  blk_len   in   BLKW  block length in bytes, sampled with start
//  abort     in   1     synchronous abort, any state
//  din       in   8     data byte
//  din_vld   in   1     din valid
//  din_rdy   out  1     prefetch buffer empty, accepts din
//  dat_o     out  1     DAT0 output value
//  dat_oe    out  1     DAT0 output enable
//  busy      out  1     not IDLE
//  done      out  1     1-clk pulse after end bit sent
//  err       out  1     1-clk pulse on underrun
// BEHAVIOUR
//  - Reset: state IDLE, dat_o=1, dat_oe=0, busy=0, done=0, err=0, din_rdy=0, CRC cleared.
//  - States: IDLE -> [PRE] -> START -> DATA -> CRC -> END -> IDLE; ERR path DATA -> IDLE.
//  - IDLE: crc clr=1; din_rdy=0. start with blk_len!=0 latches length, sets busy next clk.
//    start with blk_len==0 ignored; start while busy ignored.
//  - START: on first sd_ce drive dat_o=0, dat_oe=1. din_rdy=1 from START entry (prefetch).
//  - Datapath: 1-byte prefetch buffer + 8-bit shift reg. Handshake din_vld&din_rdy loads buffer.
//    Shift reg reloads from buffer on the sd_ce of each byte's first bit; buffer frees same clk.
//  - DATA: per sd_ce output shreg[7], crc cen=1 din=that bit; 3-bit bit cnt, BLKW byte cnt.
//    Bytes in flight: exactly blk_len accepted; din_rdy=0 once blk_len bytes taken.
//  - Underrun: byte boundary sd_ce with buffer empty -> err pulse, dat_oe=0, dat_o=1, IDLE
//    next clk; no done. Stale bytes never transmitted.
//  - CRC: 16 sd_ce cycles, dat_o=crc q (MSB first), crc sft=1, cen=0; 4-bit counter.
//  - END: one sd_ce with dat_o=1, dat_oe=1; next clk dat_oe=0, done=1, IDLE.
//  - sd_ce=0: all state, outputs, counters and CRC hold (cen=sft=0).
//  - abort: any state -> IDLE next clk, dat_oe=0, dat_o=1, buffer flushed, no done/err.
//    abort and start same clk: abort wins. Abort mid-block leaves CRC cleared for next block.
//  - Frame length: 1+8*blk_len+16+1 sd_ce cycles (plus 2 with preamble).
// CONFIGURATION
//  SD_SLV_DTX_PREAMBLE_EN defined: PRE state drives dat_o=1, dat_oe=1 for 2 sd_ce before START.
//  Undefined: no PRE state; START is first driven bit. No other differences.
// STRUCTURE
//  - Shared pkg sd_slv_pkg: state encoding localparams (IDLE,PRE,START,DATA,CRC,END),
//    CRC16_LEN=16, SD_START_BIT=0, SD_END_BIT=1.
//  - One sub-module: sd_slv_c16 CRC16 generator (rst,clk,clr,din,cen,sft,q) instantiated once;
//    FSM, counters, prefetch buffer inline.
// TESTING
//  1. blk_len=512, all 0xFF, sd_ce=1 every clk -> 0, 4096x1, CRC 0x7FA1, 1; done after 4114 ce.
//  2. blk_len=1, din=0x00 -> 0, 8x0, 16x0 (CRC 0x0000), 1; done; busy low after.
//  3. Test 1 with sd_ce every 3rd clk, din_vld random but in time -> identical bitstream.
//  4. blk_len=8, din_vld dropped after byte 3 -> err at byte-4 boundary, dat_oe=0, no done.
//  5. abort at CRC bit 5, then test 2 -> test 2 bitstream exact (CRC cleared), no done for 1st.
//  6. start with blk_len=0, and start while busy -> ignored; busy/dat_oe unchanged.

Source files
------------

// File: rtl/sd_slv_pkg.sv
// sd_slv_pkg: state encoding and SD bus framing constants shared by the SD slave blocks
package sd_slv_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4,
    S_END   = 3'd5
  } state_t;
  localparam int   CRC16_LEN    = 16;
  localparam logic SD_START_BIT = 1'b0;
  localparam logic SD_END_BIT   = 1'b1;
endpackage

// File: rtl/sd_slv_c16.sv
// sd_slv_c16: serial CRC16-CCITT (x^16+x^12+x^5+1) generator; cen absorbs din, sft shifts the remainder out on q
module sd_slv_c16 (
  input  logic rst,
  input  logic clk,
  input  logic clr,
  input  logic din,
  input  logic cen,
  input  logic sft,
  output logic q
);
  logic [15:0] r_crc;
  logic        w_fb;
  assign w_fb = din ^ r_crc[15];
  assign q    = r_crc[15];
  always_ff @(posedge clk or posedge rst)
    if (rst) r_crc <= '0;
    else if (clr) r_crc <= '0;
    else if (cen) r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
    else if (sft) r_crc <= {r_crc[14:0], 1'b0};
endmodule

// File: rtl/sd_slv_dtx.sv
// sd_slv_dtx: SD slave DAT0 read-block transmitter (start, data MSB-first, CRC16, end bit).
// Define SD_SLV_DTX_PREAMBLE_EN to drive two idle-high bits before the start bit.
module sd_slv_dtx import sd_slv_pkg::*; #(
  parameter int BLKW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sd_ce,
  input  logic            start,
  input  logic [BLKW-1:0] blk_len,
  input  logic            abort,
  input  logic [7:0]      din,
  input  logic            din_vld,
  output logic            din_rdy,
  output logic            dat_o,
  output logic            dat_oe,
  output logic            busy,
  output logic            done,
  output logic            err
);
`ifdef SD_SLV_DTX_PREAMBLE_EN
  localparam state_t FIRST = S_PRE;
`else
  localparam state_t FIRST = S_START;
`endif
  state_t          r_state, w_nxt;
  logic [BLKW-1:0] r_len, r_acc, r_byte;
  logic [2:0]      r_bit;
  logic [3:0]      r_cnt;
  logic [7:0]      r_buf, r_sh;
  logic            r_full, r_eb, r_dat_o, r_dat_oe, r_done, r_err;
  logic            w_go, w_tx, w_hs, w_ur, w_clr, w_cen, w_sft, w_crc_q;
  assign w_go    = start && blk_len != '0;
  assign w_tx    = (r_bit == 3'd0) ? r_buf[7] : r_sh[7];
  assign w_hs    = din_vld && din_rdy;
  assign w_ur    = r_state == S_DATA && sd_ce && r_bit == 3'd0 && !r_full;
  assign w_clr   = r_state == S_IDLE;
  assign din_rdy = (r_state == S_START || r_state == S_DATA) && !r_full && r_acc != r_len;
  assign dat_o   = r_dat_o;
  assign dat_oe  = r_dat_oe;
  assign busy    = r_state != S_IDLE;
  assign done    = r_done;
  assign err     = r_err;
  sd_slv_c16 u_crc (
    .rst (rst),
    .clk (clk),
    .clr (w_clr),
    .din (w_tx),
    .cen (w_cen),
    .sft (w_sft),
    .q   (w_crc_q)
  );
  always_comb begin
    w_nxt = r_state;
    w_cen = 1'b0;
    w_sft = 1'b0;
    case (r_state)
      S_IDLE:  w_nxt = w_go ? FIRST : S_IDLE;
      S_PRE:   w_nxt = (sd_ce && r_cnt == 4'd1) ? S_START : S_PRE;
      S_START: w_nxt = sd_ce ? S_DATA : S_START;
      S_DATA: begin
        w_cen = sd_ce && !w_ur;
        w_nxt = w_ur ? S_IDLE :
                (w_cen && r_bit == 3'd7 && r_byte == r_len - BLKW'(1)) ? S_CRC : S_DATA;
      end
      S_CRC: begin
        w_sft = sd_ce;
        w_nxt = (sd_ce && r_cnt == 4'(CRC16_LEN - 1)) ? S_END : S_CRC;
      end
      S_END:   w_nxt = r_eb ? S_IDLE : S_END;
      default: w_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_nxt = S_IDLE;
      w_cen = 1'b0;
      w_sft = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_nxt;
  // Datapath: prefetch buffer feeds the shift register on each byte's first bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_len    <= '0;
      r_acc    <= '0;
      r_byte   <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_sh     <= '0;
      r_full   <= 1'b0;
      r_eb     <= 1'b0;
      r_dat_o  <= 1'b1;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_hs) begin
        r_buf  <= din;
        r_full <= 1'b1;
        r_acc  <= r_acc + BLKW'(1);
      end
      case (r_state)
        S_IDLE: if (w_go) begin
          r_len  <= blk_len;
          r_acc  <= '0;
          r_byte <= '0;
          r_bit  <= '0;
          r_cnt  <= '0;
          r_full <= 1'b0;
          r_eb   <= 1'b0;
        end
        S_PRE: if (sd_ce) begin
          r_dat_o  <= SD_END_BIT;
          r_dat_oe <= 1'b1;
          r_cnt    <= r_cnt + 4'd1;
        end
        S_START: if (sd_ce) begin
          r_dat_o  <= SD_START_BIT;
          r_dat_oe <= 1'b1;
          r_cnt    <= '0;
        end
        S_DATA: if (w_ur) begin
          r_err    <= 1'b1;
          r_dat_oe <= 1'b0;
          r_dat_o  <= 1'b1;
        end else if (sd_ce) begin
          r_dat_o <= w_tx;
          r_bit   <= r_bit + 3'd1;
          r_sh    <= (r_bit == 3'd0) ? {r_buf[6:0], 1'b0} : {r_sh[6:0], 1'b0};
          if (r_bit == 3'd0) r_full <= 1'b0;
          if (r_bit == 3'd7) r_byte <= r_byte + BLKW'(1);
        end
        S_CRC: if (sd_ce) begin
          r_dat_o <= w_crc_q;
          r_cnt   <= r_cnt + 4'd1;
        end
        S_END: if (r_eb) begin
          r_dat_oe <= 1'b0;
          r_done   <= 1'b1;
          r_eb     <= 1'b0;
        end else if (sd_ce) begin
          r_dat_o  <= SD_END_BIT;
          r_dat_oe <= 1'b1;
          r_eb     <= 1'b1;
        end
        default: ;
      endcase
      if (abort) begin
        r_dat_oe <= 1'b0;
        r_dat_o  <= 1'b1;
        r_full   <= 1'b0;
        r_eb     <= 1'b0;
        r_done   <= 1'b0;
        r_err    <= 1'b0;
      end
    end
endmodule
